// File: rtl/hist_eq_div_array.sv
// hist_eq_div_array: N-lane histogram-equalisation divider with its own
// memory sequencer. Each lane computes
//   round((cdf - cdf_min) * (2^GW - 1) / (pix_total - cdf_min))
// using a shared-counter restoring divider, one quotient bit per cycle.
// Optional build macro: HEQ_ROUND_EN (round-half-up); undefined = truncate.
module hist_eq_div_array #(
  parameter int LANES     = 8,
  parameter int DW        = 32,
  parameter int GW        = 8,
  parameter int AW        = 16,
  parameter int NUM_WORDS = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DW-1:0]         cdf_min,
  input  logic [DW-1:0]         pix_total,
  input  logic [AW-1:0]         rd_base,
  input  logic [AW-1:0]         wt_base,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_rd_addr,
  input  logic [LANES*DW-1:0]   mem_rd_data,
  output logic                  mem_wt_en,
  output logic [AW-1:0]         mem_wt_addr,
  output logic [LANES*DW-1:0]   mem_wt_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_div0
);

  localparam int NW = DW + GW + 1;
  localparam int CW = $clog2(NW + 1);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [GW-1:0] GMAX     = {GW{1'b1}};
  localparam logic [NW-1:0] GMAX_EXT = {{(NW-GW){1'b0}}, GMAX};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RD = 3'd1, S_WAIT = 3'd2, S_LOAD = 3'd3,
    S_DIV = 3'd4, S_WR = 3'd5, S_DONE = 3'd6
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic [LW-1:0]   wait_r;
  logic [CW-1:0]   cnt_r;
  logic [DW-1:0]   cdf_min_r;
  logic [DW-1:0]   pix_total_r;
  logic [AW-1:0]   rd_base_r;
  logic [AW-1:0]   wt_base_r;
  logic [NW-1:0]   quo_r    [LANES];
  logic [DW-1:0]   rem_r    [LANES];

  logic [DW-1:0]         den_s;
  logic [DW-1:0]         rnd_s;
  logic [DW-1:0]         cdf_s;
  logic [DW-1:0]         d_s;
  logic [DW:0]           rem_sh_s;
  logic [DW:0]           diff_s;
  logic                  ge_s;
  logic [GW-1:0]         res_s;
  logic [NW-1:0]         num_s    [LANES];
  logic [NW-1:0]         quo_nx_s [LANES];
  logic [DW-1:0]         rem_nx_s [LANES];
  logic [LANES*DW-1:0]   wt_data_s;

  // Per-lane numerator build, one restoring-division step, and clamped result.
  always_comb begin
    den_s = pix_total_r - cdf_min_r;
`ifdef HEQ_ROUND_EN
    rnd_s = {1'b0, den_s[DW-1:1]};
`else
    rnd_s = {DW{1'b0}};
`endif
    cdf_s     = {DW{1'b0}};
    d_s       = {DW{1'b0}};
    rem_sh_s  = {(DW+1){1'b0}};
    diff_s    = {(DW+1){1'b0}};
    ge_s      = 1'b0;
    res_s     = {GW{1'b0}};
    wt_data_s = {(LANES*DW){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      cdf_s = mem_rd_data[i*DW +: DW];
      if (cdf_s > cdf_min_r) begin
        d_s = cdf_s - cdf_min_r;
      end else begin
        d_s = {DW{1'b0}};
      end
      // d*(2^GW-1) as (d<<GW)-d keeps the product in NW bits.
      num_s[i] = (NW'(d_s) << GW) - NW'(d_s) + NW'(rnd_s);

      // A borrow out of the trial subtraction means the shifted remainder < den.
      rem_sh_s = {rem_r[i], quo_r[i][NW-1]};
      diff_s   = rem_sh_s - {1'b0, den_s};
      ge_s     = ~diff_s[DW];
      if (ge_s) begin
        rem_nx_s[i] = diff_s[DW-1:0];
      end else begin
        rem_nx_s[i] = rem_sh_s[DW-1:0];
      end
      quo_nx_s[i] = {quo_r[i][NW-2:0], ge_s};

      if (err_div0) begin
        res_s = {GW{1'b0}};
      end else if (quo_nx_s[i] > GMAX_EXT) begin
        res_s = GMAX;
      end else begin
        res_s = quo_nx_s[i][GW-1:0];
      end
      wt_data_s[i*DW +: DW] = {{(DW-GW){1'b0}}, res_s};
    end
  end

  // Sequencer FSM: read word, wait out latency, load, divide, write, repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      idx_r       <= {IW{1'b0}};
      wait_r      <= {LW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      cdf_min_r   <= {DW{1'b0}};
      pix_total_r <= {DW{1'b0}};
      rd_base_r   <= {AW{1'b0}};
      wt_base_r   <= {AW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
        quo_r[i] <= {NW{1'b0}};
        rem_r[i] <= {DW{1'b0}};
      end
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= {AW{1'b0}};
      mem_wt_en   <= 1'b0;
      mem_wt_addr <= {AW{1'b0}};
      mem_wt_data <= {(LANES*DW){1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      err_div0    <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wt_en <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cdf_min_r   <= cdf_min;
            pix_total_r <= pix_total;
            rd_base_r   <= rd_base;
            wt_base_r   <= wt_base;
            idx_r       <= {IW{1'b0}};
            err_div0    <= (pix_total == cdf_min);
            busy        <= 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= rd_base;
            state_r     <= S_RD;
          end
        end
        S_RD: begin
          wait_r <= {LW{1'b0}};
          if (RD_LAT > 1) begin
            state_r <= S_WAIT;
          end else begin
            state_r <= S_LOAD;
          end
        end
        S_WAIT: begin
          if (wait_r == LW'(RD_LAT - 2)) begin
            state_r <= S_LOAD;
          end else begin
            wait_r <= wait_r + {{(LW-1){1'b0}}, 1'b1};
          end
        end
        S_LOAD: begin
          for (int i = 0; i < LANES; i++) begin
            quo_r[i] <= num_s[i];
            rem_r[i] <= {DW{1'b0}};
          end
          cnt_r   <= {CW{1'b0}};
          state_r <= S_DIV;
        end
        S_DIV: begin
          for (int i = 0; i < LANES; i++) begin
            quo_r[i] <= quo_nx_s[i];
            rem_r[i] <= rem_nx_s[i];
          end
          // The final step's quotient goes straight to the write registers.
          if (cnt_r == CW'(NW - 1)) begin
            mem_wt_en   <= 1'b1;
            mem_wt_addr <= wt_base_r + AW'(idx_r);
            mem_wt_data <= wt_data_s;
            state_r     <= S_WR;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_WR: begin
          if (idx_r == IW'(NUM_WORDS - 1)) begin
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            idx_r       <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= rd_base_r + AW'(idx_r) + {{(AW-1){1'b0}}, 1'b1};
            state_r     <= S_RD;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hist_eq_div_array.sv
// Directed testbench for hist_eq_div_array (default parameters).
module tb_hist_eq_div_array;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  cdf_min;
  logic [31:0]  pix_total;
  logic [15:0]  rd_base;
  logic [15:0]  wt_base;
  logic         mem_rd_en;
  logic [15:0]  mem_rd_addr;
  logic [255:0] mem_rd_data;
  logic         mem_wt_en;
  logic [15:0]  mem_wt_addr;
  logic [255:0] mem_wt_data;
  logic         busy;
  logic         done;
  logic         err_div0;

  hist_eq_div_array dut (
    .clk(clk), .reset(reset), .start(start), .cdf_min(cdf_min),
    .pix_total(pix_total), .rd_base(rd_base), .wt_base(wt_base),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wt_en(mem_wt_en), .mem_wt_addr(mem_wt_addr), .mem_wt_data(mem_wt_data),
    .busy(busy), .done(done), .err_div0(err_div0)
  );

  always #5 clk = ~clk;

  // Lane cdf values, lane 7 .. lane 0
  localparam logic [255:0] PAT = {32'd260, 32'd760, 32'd11, 32'd10,
                                  32'd2010, 32'd1010, 32'd5, 32'd510};
  // Hand-computed results for cdf_min=10, pix_total=1010 (den=1000)
`ifdef HEQ_ROUND_EN
  localparam logic [255:0] EXP = {32'd64, 32'd191, 32'd0, 32'd0,
                                  32'd255, 32'd255, 32'd0, 32'd128};
`else
  localparam logic [255:0] EXP = {32'd63, 32'd191, 32'd0, 32'd0,
                                  32'd255, 32'd255, 32'd0, 32'd127};
`endif

  // Memory model with one cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= PAT;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           checks = 0;
  int           errors = 0;
  int           base = 0;
  logic         log_on = 1'b0;
  logic         log_clr = 1'b0;
  int           rd_n, wr_n, done_n, done_cyc, busy_low_cyc;
  logic [15:0]  rd_addr_l [64];
  int           rd_cyc_l  [64];
  logic [15:0]  wr_addr_l [64];
  int           wr_cyc_l  [64];
  logic [255:0] wr_data_l [64];

  // Bus monitor, sampled on the falling edge; cycle numbers relative to start
  always @(negedge clk) begin
    int rel;
    rel = cyc - base + 1;
    if (log_clr) begin
      rd_n = 0; wr_n = 0; done_n = 0; done_cyc = -1; busy_low_cyc = -1;
    end else if (log_on) begin
      if (mem_rd_en) begin
        if (rd_n < 64) begin rd_addr_l[rd_n] = mem_rd_addr; rd_cyc_l[rd_n] = rel; end
        rd_n++;
      end
      if (mem_wt_en) begin
        if (wr_n < 64) begin
          wr_addr_l[wr_n] = mem_wt_addr; wr_cyc_l[wr_n] = rel; wr_data_l[wr_n] = mem_wt_data;
        end
        wr_n++;
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = rel;
      end
      if (!busy && busy_low_cyc < 0) busy_low_cyc = rel;
    end
  end

  task automatic chk_v(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_v({tag, "_rd_en"},   {255'd0, mem_rd_en},   256'd0);
    chk_v({tag, "_rd_addr"}, {240'd0, mem_rd_addr}, 256'd0);
    chk_v({tag, "_wt_en"},   {255'd0, mem_wt_en},   256'd0);
    chk_v({tag, "_wt_addr"}, {240'd0, mem_wt_addr}, 256'd0);
    chk_v({tag, "_wt_data"}, mem_wt_data,           256'd0);
    chk_v({tag, "_busy"},    {255'd0, busy},        256'd0);
    chk_v({tag, "_done"},    {255'd0, done},        256'd0);
    chk_v({tag, "_err"},     {255'd0, err_div0},    256'd0);
  endtask

  // Presents start for one edge; returns #1 after the accepting edge
  task automatic start_run(input logic [31:0] cm, input logic [31:0] pt,
                           input logic [15:0] rb, input logic [15:0] wb);
    @(posedge clk); #1;
    cdf_min = cm; pix_total = pt; rd_base = rb; wt_base = wb;
    start = 1'b1; log_on = 1'b0; log_clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base = cyc; log_clr = 1'b0; log_on = 1'b1;
    chk_v("accept_busy",    {255'd0, busy},        256'd1);
    chk_v("accept_rd_en",   {255'd0, mem_rd_en},   256'd1);
    chk_v("accept_rd_addr", {240'd0, mem_rd_addr}, {240'd0, rb});
  endtask

  task automatic wait_to(input int rel_cyc);
    while (cyc - base + 1 < rel_cyc) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_n == 0 && n < 3000) begin @(posedge clk); #1; n++; end
    repeat (2) begin @(posedge clk); #1; end
    chk_i("done_seen", done_n, 1);
  endtask

  task automatic check_run(input logic [15:0] rb, input logic [15:0] wb,
                           input logic [255:0] exp_word);
    logic [15:0] a;
    chk_i("rd_count", rd_n, 32);
    chk_i("wr_count", wr_n, 32);
    for (int k = 0; k < 32; k++) begin
      a = rb + 16'(k);
      chk_v("rd_addr", {240'd0, rd_addr_l[k]}, {240'd0, a});
      chk_i("rd_cycle", rd_cyc_l[k], 1 + 44 * k);
      a = wb + 16'(k);
      chk_v("wr_addr", {240'd0, wr_addr_l[k]}, {240'd0, a});
      chk_i("wr_cycle", wr_cyc_l[k], 44 * (k + 1));
      chk_v("wr_data", wr_data_l[k], exp_word);
    end
    chk_i("done_cycle", done_cyc, 1409);
    chk_i("busy_low_cycle", busy_low_cyc, 1410);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    cdf_min = 32'd0; pix_total = 32'd0; rd_base = 16'd0; wt_base = 16'd0;
    #1;
    chk_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Run A: normal pass, with a start pulse at cycle 100 that must be ignored
    start_run(32'd10, 32'd1010, 16'h0100, 16'h0200);
    chk_v("a_err_clear", {255'd0, err_div0}, 256'd0);
    wait_to(100);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    check_run(16'h0100, 16'h0200, EXP);
    chk_v("a_idle_busy", {255'd0, busy}, 256'd0);

    // Run B: pix_total == cdf_min -> sticky err_div0, all lanes zero
    start_run(32'd10, 32'd10, 16'h0100, 16'h0200);
    chk_v("b_err_set", {255'd0, err_div0}, 256'd1);
    wait_done();
    check_run(16'h0100, 16'h0200, 256'd0);
    chk_v("b_err_sticky", {255'd0, err_div0}, 256'd1);

    // Run C: next start clears err_div0; reset asserted at cycle 500
    start_run(32'd10, 32'd1010, 16'h0100, 16'h0200);
    chk_v("c_err_cleared", {255'd0, err_div0}, 256'd0);
    wait_to(500);
    #2 reset = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk_i("c_wr_count", wr_n, 11);
    chk_i("c_no_done", done_n, 0);
    chk_v("c_busy_low", {255'd0, busy}, 256'd0);

    // Run D: fresh full pass with addresses wrapping past 0xFFFF
    start_run(32'd10, 32'd1010, 16'hFFF0, 16'hFFF8);
    wait_done();
    check_run(16'hFFF0, 16'hFFF8, EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_eq_div_array.md
# hist_eq_div_array

Parametrised N-lane histogram-equalisation divider engine with its own memory sequencer. It reads packed CDF words from scratch memory and computes one equalised gray level per lane as round((cdf − cdf_min)·(2^GW − 1) / (pix_total − cdf_min)). It writes the packed results back to scratch memory and signals completion. It replaces the fixed 8-lane, 32-bit divider top with a generalised lane count, widths, read latency and base addresses, and adds divide-by-zero and overflow handling.

## Interface
- LANES, 8, divider lanes per memory word
- DW, 32, CDF / pixel-count width
- GW, 8, output gray-level width (GW < DW)
- AW, 16, memory address width
- NUM_WORDS, 32, words processed per run (LANES·NUM_WORDS = bins)
- RD_LAT, 1, memory read latency in cycles (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  run request; accepted only in IDLE
- cdf_min  in  DW  minimum nonzero CDF; sampled at accepted start
- pix_total  in  DW  total pixel count; sampled at accepted start
- rd_base  in  AW  first read address; sampled at start
- wt_base  in  AW  first write address; sampled at start
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  AW  read address
- mem_rd_data  in  LANES·DW  lane i = bits [i·DW +: DW]
- mem_wt_en  out  1  write strobe
- mem_wt_addr  out  AW  write address
- mem_wt_data  out  LANES·DW  lane i result zero-extended to DW, at [i·DW +: DW]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- err_div0  out  1  sticky: pix_total == cdf_min at start

## Operation
- FSM states: IDLE, RD, WAIT, LOAD, DIV, WR, DONE.
- IDLE: on start=1, capture the inputs, set idx=0 and clear err_div0. Set err_div0=1 if pix_total == cdf_min. Go to RD.
- RD: mem_rd_en=1, mem_rd_addr=rd_base+idx. Go to WAIT, or to LOAD directly when RD_LAT=1.
- WAIT: RD_LAT−1 cycles, then LOAD.
- LOAD: sample mem_rd_data. Per lane:
  - d = cdf>cdf_min ? cdf−cdf_min : 0
  - num = d·(2^GW−1) + rnd, held in DW+GW+1 bits
  - den = pix_total−cdf_min
- DIV: shared-counter restoring division, one quotient bit per cycle, DW+GW+1 cycles, all lanes in parallel.
- WR: mem_wt_en=1, mem_wt_addr=wt_base+idx.
  - Lane result = min(q, 2^GW−1).
  - If err_div0, lane result = 0.
  - If idx==NUM_WORDS−1 go to DONE; otherwise idx+1 and go to RD.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored while busy. Address sums wrap modulo 2^AW.
- reset low at any time: all state and outputs clear immediately. No further reads or writes are issued, and a write in progress is dropped.

## Timing
- Reset values: mem_rd_en=0, mem_wt_en=0, mem_rd_addr=0, mem_wt_addr=0, mem_wt_data=0, busy=0, done=0, err_div0=0; FSM in IDLE.
- Name the accepting edge of start cycle 0. RD of word 0 is cycle 1.
- Per word: RD_LAT + 2 + (DW+GW+1) cycles. Defaults: 44.
- The word-k write occurs at cycle (k+1)·44 − 0 relative to RD of word 0 (RD at cycle 1 + 44k, WR at cycle 44 + 44k).
- done pulses at cycle 1 + NUM_WORDS·44 = 1409 with defaults. busy drops the following cycle.
- mem_wt_data and mem_wt_addr are valid only while mem_wt_en=1. Both hold their values otherwise.
- Exactly one read and one write per word, strictly in address order.

## Configuration
- HEQ_ROUND_EN defined: rnd = floor(den/2), giving round-half-up.
- HEQ_ROUND_EN undefined: rnd = 0, giving a truncating quotient.
- Latency is identical in both builds.

## Test plan
- Defaults, HEQ_ROUND_EN defined; cdf_min=10, pix_total=1010; lane cdf=510 -> result 128. Without HEQ_ROUND_EN -> 127.
- Lane cdf=5 (< cdf_min) -> 0. Lane cdf=1010 -> 255. Lane cdf=2010 -> clamps to 255.
- Full run with rd_base=0x0100, wt_base=0x0200 -> 32 reads and 32 writes at 0x0100..0x011F and 0x0200..0x021F; writes at cycles 44, 88, …; done at cycle 1409; busy deasserts at 1410.
- pix_total=cdf_min=10 -> err_div0=1 from cycle 1; all written lanes 0; done still at cycle 1409. The next start clears err_div0.
- start pulsed at cycle 100 mid-run -> ignored; write count stays 32.
- reset asserted at cycle 500 -> outputs at reset values same cycle; no mem_wt_en after. A fresh start runs a full, correct 32-word pass.
